memory_controller: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 36 +++
 rtl/memory_controller.sv | 209 ++++++++++++++++++++
 tb/tb_memory_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_LSU    = 1'b1
  } src_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // IO space is the top quarter of the byte address map (top two bits set).
  localparam logic [1:0] IO_PREFIX = 2'b11;

  function automatic logic is_io(input logic [1:0] addr_top);
    return addr_top == IO_PREFIX;
  endfunction

  // Size code 3 is illegal and handled as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller.sv
// Arbitrates the byte-wide RAM/IO port between icache line fills and LSU
// accesses, serializing each request into per-byte memory cycles.
//
// state | meaning
// IDLE  | port quiet (mem_a = 0); arbitrate and issue byte 0 at the grant edge
// READ  | cnt = edges since grant; issue while cnt < N, capture byte cnt-2
// WRITE | cnt = bytes written; IO writes hold while the UART buffer is full
// DONE  | done pulse for the granted source; no new grant this cycle
module memory_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    icache_req,
  input  logic [ADDR_WIDTH-1:0]   icache_addr,
  output logic                    icache_done,
  output logic [LINE_BYTES*8-1:0] icache_data,
  input  logic                    lsu_req,
  input  logic                    lsu_we,
  input  logic [1:0]              lsu_size,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic [31:0]             lsu_wdata,
  output logic                    lsu_done,
  output logic [31:0]             lsu_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_WIDTH-1:0]   mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int CNT_W = $clog2(LINE_BYTES + 2);
  localparam int IDX_W = $clog2(LINE_BYTES);

  state_t                  state, state_nxt;
  src_t                    src_q, last_grant;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]        n_q;
  logic [CNT_W-1:0]        cnt;
  logic [31:0]             wdata_q;
  logic [LINE_BYTES*8-1:0] line_buf;

  logic                    grant;
  src_t                    grant_src;
  logic                    cur_we;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [31:0]             cur_wdata;
  logic [CNT_W-1:0]        cur_n;
  logic [CNT_W-1:0]        cur_cnt;
  logic [ADDR_WIDTH-1:0]   issue_addr;
  logic                    stall;

  logic                    issue, capture, finish, addr_zero, cnt_inc;
  logic [IDX_W-1:0]        cap_idx;
  logic [LINE_BYTES*8-1:0] buf_nxt;
  logic [31:0]             lsu_rdata_nxt;

  // Tie goes to whichever source was not granted last.
  always_comb begin
    grant     = 1'b0;
    grant_src = SRC_ICACHE;
    if (state == IDLE) begin
      if (icache_req && lsu_req) begin
        grant     = 1'b1;
        grant_src = (last_grant == SRC_ICACHE) ? SRC_LSU : SRC_ICACHE;
      end else if (icache_req) begin
        grant     = 1'b1;
        grant_src = SRC_ICACHE;
      end else if (lsu_req) begin
        grant     = 1'b1;
        grant_src = SRC_LSU;
      end
    end
  end

  // At the grant edge the operands come straight from the requester.
  always_comb begin
    if (grant) begin
      cur_we    = (grant_src == SRC_LSU) && lsu_we;
      cur_addr  = (grant_src == SRC_LSU) ? lsu_addr : icache_addr;
      cur_wdata = lsu_wdata;
      cur_n     = (grant_src == SRC_LSU) ? CNT_W'(size_bytes(lsu_size))
                                         : CNT_W'(LINE_BYTES);
      cur_cnt   = '0;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_n     = n_q;
      cur_cnt   = cnt;
    end
    issue_addr = cur_addr + ADDR_WIDTH'(cur_cnt);
    stall      = cur_we && is_io(cur_addr[ADDR_WIDTH-1 -: 2]) && io_buffer_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = cur_we ? WRITE : READ;
      READ:    if (cnt == n_q + CNT_W'(1)) state_nxt = DONE;
      WRITE:   if (cnt == n_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue     = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    addr_zero = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        issue     = grant && !stall;
        addr_zero = !grant;
      end
      READ: begin
        issue   = cnt < n_q;
        capture = cnt >= CNT_W'(2);
        finish  = cnt == n_q + CNT_W'(1);
        cnt_inc = 1'b1;
      end
      WRITE: begin
        finish  = cnt == n_q;
        issue   = !finish && !stall;
        cnt_inc = issue;
      end
      DONE: addr_zero = 1'b1;
      default: ;
    endcase
  end

  // Read byte k arrives two edges after its issue, i.e. when cnt = k + 2.
  always_comb begin
    cap_idx = IDX_W'(cnt - CNT_W'(2));
    buf_nxt = line_buf;
    buf_nxt[{cap_idx, 3'b000} +: 8] = mem_din;
    case (n_q)
      CNT_W'(1): lsu_rdata_nxt = {24'h0, buf_nxt[7:0]};
      CNT_W'(2): lsu_rdata_nxt = {16'h0, buf_nxt[15:0]};
      default:   lsu_rdata_nxt = buf_nxt[31:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q       <= SRC_ICACHE;
      last_grant  <= SRC_ICACHE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      n_q         <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      line_buf    <= '0;
      mem_a       <= '0;
      mem_dout    <= '0;
      mem_wr      <= 1'b0;
      icache_done <= 1'b0;
      lsu_done    <= 1'b0;
      icache_data <= '0;
      lsu_rdata   <= '0;
    end else if (rdy) begin
      if (grant) begin
        src_q      <= grant_src;
        last_grant <= grant_src;
        we_q       <= cur_we;
        addr_q     <= cur_addr;
        n_q        <= cur_n;
        wdata_q    <= cur_wdata;
      end

      if (state == IDLE) begin
        cnt <= issue ? CNT_W'(1) : '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CNT_W'(1);
      end

      mem_wr <= issue && cur_we;
      if (issue) begin
        mem_a <= issue_addr;
        if (cur_we) mem_dout <= cur_wdata[{cur_cnt[1:0], 3'b000} +: 8];
      end else if (addr_zero) begin
        mem_a <= '0;
      end

      if (capture) line_buf <= buf_nxt;

      icache_done <= finish && (src_q == SRC_ICACHE);
      lsu_done    <= finish && (src_q == SRC_LSU);
      if (finish && (src_q == SRC_ICACHE)) icache_data <= buf_nxt;
      if (finish && (src_q == SRC_LSU) && !we_q) lsu_rdata <= lsu_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: loads, line fills, arbitration,
// IO-stalled stores, address wrap and mid-transfer reset.
module tb_memory_controller;

  localparam int AW = 17;
  localparam int LB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b1;
  logic          icache_req = 1'b0;
  logic [AW-1:0] icache_addr = '0;
  logic          icache_done;
  logic [LB*8-1:0] icache_data;
  logic          lsu_req = 1'b0;
  logic          lsu_we = 1'b0;
  logic [1:0]    lsu_size = 2'd0;
  logic [AW-1:0] lsu_addr = '0;
  logic [31:0]   lsu_wdata = '0;
  logic          lsu_done;
  logic [31:0]   lsu_rdata;
  logic [7:0]    mem_din = '0;
  logic [7:0]    mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;
  logic          io_buffer_full = 1'b0;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [7:0]    pl_d = '0;
  logic [7:0]    ram [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  memory_controller #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_done(icache_done), .icache_data(icache_data),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data for an address appears the cycle after it.
  always @(posedge clk) begin
    mem_din <= ram[mem_a];
    if (pl_en) ram[pl_a] <= pl_d;
    else if (mem_wr) ram[mem_a] <= mem_dout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    tick();
    pl_en = 1'b0;
  endtask

  initial begin
    logic [LB*8-1:0] exp_line;
    logic            seen;

    tick();
    preload(17'h00104, 8'h11);
    preload(17'h00105, 8'h22);
    preload(17'h00106, 8'h33);
    preload(17'h00107, 8'h44);
    for (int k = 0; k < 16; k++) preload(AW'(17'h00200 + k), 8'(8'hA0 + k));
    preload(17'h00300, 8'h5A);
    preload(17'h1FFFF, 8'h77);
    preload(17'h00000, 8'h88);
    rst = 1'b0;

    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_dout", mem_dout, 0);
    check("rst_icache_done", icache_done, 0);
    check("rst_lsu_done", lsu_done, 0);
    check("rst_icache_data", icache_data, 0);
    check("rst_lsu_rdata", lsu_rdata, 0);

    // Word load at 0x104
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'd2; lsu_addr = 17'h00104;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wl_addr%0d", k), mem_a, 17'h00104 + k);
      check($sformatf("wl_wr%0d", k), mem_wr, 0);
      tick();
    end
    check("wl_done_early", lsu_done, 0);
    tick();
    check("wl_done", lsu_done, 1);
    check("wl_rdata", lsu_rdata, 32'h44332211);
    lsu_req = 1'b0;
    tick();
    check("wl_done_pulse", lsu_done, 0);

    // Line fill at 0x200
    icache_req = 1'b1; icache_addr = 17'h00200;
    tick();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("lf_addr%0d", k), mem_a, 17'h00200 + k);
      tick();
    end
    check("lf_done_early", icache_done, 0);
    tick();
    for (int k = 0; k < 16; k++) exp_line[8*k +: 8] = 8'(8'hA0 + k);
    check("lf_done", icache_done, 1);
    check("lf_data", icache_data, exp_line);
    icache_req = 1'b0;
    tick();
    check("lf_done_pulse", icache_done, 0);

    // Arbitration after reset: LSU, icache, LSU
    rst = 1'b1;
    tick();
    rst = 1'b0;
    icache_req = 1'b1; icache_addr = 17'h00400;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'd0; lsu_addr = 17'h00300;
    tick();
    check("arb_first_lsu", mem_a, 17'h00300);
    tick();
    tick();
    check("arb_lsu_done", lsu_done, 1);
    check("arb_lsu_rdata", lsu_rdata, 32'h0000005A);
    tick();
    check("arb_done_idle_addr", mem_a, 0);
    tick();
    check("arb_second_icache", mem_a, 17'h00400);
    repeat (17) tick();
    check("arb_icache_done", icache_done, 1);
    tick();
    tick();
    check("arb_third_lsu", mem_a, 17'h00300);
    icache_req = 1'b0;
    tick();
    tick();
    check("arb_lsu2_done", lsu_done, 1);
    lsu_req = 1'b0;
    tick();

    // RAM byte store ignores io_buffer_full
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'd0; lsu_addr = 17'h00500;
    lsu_wdata = 32'h000000C3; io_buffer_full = 1'b1;
    tick();
    check("ram_st_wr", mem_wr, 1);
    check("ram_st_addr", mem_a, 17'h00500);
    check("ram_st_dout", mem_dout, 8'hC3);
    tick();
    check("ram_st_done", lsu_done, 1);
    check("ram_st_wr_off", mem_wr, 0);
    lsu_req = 1'b0; io_buffer_full = 1'b0;
    tick();

    // IO half store, UART buffer full for three edges
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'd1; lsu_addr = 17'h18000;
    lsu_wdata = 32'h0000BEEF; io_buffer_full = 1'b1;
    tick();
    check("io_stall_c1", mem_wr, 0);
    tick();
    check("io_stall_c2", mem_wr, 0);
    tick();
    check("io_stall_c3", mem_wr, 0);
    io_buffer_full = 1'b0;
    tick();
    check("io_b0_wr", mem_wr, 1);
    check("io_b0_addr", mem_a, 17'h18000);
    check("io_b0_dout", mem_dout, 8'hEF);
    tick();
    check("io_b1_wr", mem_wr, 1);
    check("io_b1_addr", mem_a, 17'h18001);
    check("io_b1_dout", mem_dout, 8'hBE);
    tick();
    check("io_done", lsu_done, 1);
    check("io_wr_off", mem_wr, 0);
    check("io_ram0", ram[17'h18000], 8'hEF);
    check("io_ram1", ram[17'h18001], 8'hBE);
    lsu_req = 1'b0;
    tick();

    // Byte load at the top of the map, then a wrapping half load
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'd0; lsu_addr = 17'h1FFFF;
    tick();
    check("bl_addr", mem_a, 17'h1FFFF);
    tick();
    tick();
    check("bl_done", lsu_done, 1);
    check("bl_rdata", lsu_rdata, 32'h00000077);
    lsu_req = 1'b0;
    tick();
    lsu_req = 1'b1; lsu_size = 2'd1;
    tick();
    check("hl_addr0", mem_a, 17'h1FFFF);
    tick();
    check("hl_addr1_wrap", mem_a, 17'h00000);
    tick();
    tick();
    check("hl_done", lsu_done, 1);
    check("hl_rdata", lsu_rdata, 32'h00008877);
    lsu_req = 1'b0;
    tick();

    // Reset in cycle 5 of a line fill
    icache_req = 1'b1; icache_addr = 17'h00200;
    tick();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("abort_mem_wr", mem_wr, 0);
    check("abort_mem_a", mem_a, 0);
    check("abort_done", icache_done, 0);
    check("abort_data", icache_data, 0);
    rst = 1'b0;
    icache_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      seen = seen | icache_done | mem_wr;
      tick();
    end
    check("abort_quiet", seen, 0);

    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'd2; lsu_addr = 17'h00104;
    repeat (6) tick();
    check("post_rst_done", lsu_done, 1);
    check("post_rst_rdata", lsu_rdata, 32'h44332211);
    lsu_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
